// File: rtl/bure_if_prefetch.sv
// Instruction prefetch unit: sequential fetch, in-order response buffering
// and redirect flush feeding the decode stage over valid/ready.
module bure_if_prefetch #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_gnt,
  input  logic                   i_imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic                  run;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         tg_wr;
  logic [PW-1:0]         tg_rd;

  logic [INSTR_WIDTH-1:0] dmem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pmem [DEPTH];
  logic [ADDR_WIDTH-1:0]  tmem [DEPTH];

  logic [CW:0]   used;
  logic          grant;
  logic          rv;
  logic          drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight_nxt;
  logic          unused_bits;

  assign unused_bits = ^i_redirect_pc[1:0];

  assign used  = {1'b0, inflight} + {1'b0, count};
  assign o_imem_req  = run & ~i_redirect & (used < DEPTH_W);
  assign o_imem_addr = pc;

  // rvalid with nothing outstanding is ignored entirely
  assign grant = o_imem_req & i_imem_gnt;
  assign rv    = i_imem_rvalid & (inflight != '0);
  assign drop  = rv & (discard != '0);
  assign push  = rv & ~drop & ~i_redirect;
  assign pop   = o_instr_valid & i_instr_ready & ~i_redirect;

  assign inflight_nxt = inflight + CW'(grant) - CW'(rv);

  assign o_instr_valid = (count != '0);
  assign o_instr    = o_instr_valid ? dmem[rd_ptr] : '0;
  assign o_instr_pc = o_instr_valid ? pmem[rd_ptr] : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tg_wr    <= '0;
      tg_rd    <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight_nxt;
      if (i_redirect) begin
        pc      <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        discard <= inflight - CW'(rv);
        count   <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        tg_wr   <= '0;
        tg_rd   <= '0;
      end else begin
        if (grant) begin
          pc    <= pc + ADDR_WIDTH'(4);
          tg_wr <= tg_wr + PONE;
        end
        if (drop)
          discard <= discard - ONE;
        if (push) begin
          tg_rd  <= tg_rd + PONE;
          wr_ptr <= wr_ptr + PONE;
        end
        if (pop)
          rd_ptr <= rd_ptr + PONE;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage only; validity is tracked by the counters above
  always_ff @(posedge i_clk) begin
    if (grant)
      tmem[tg_wr] <= pc;
    if (push) begin
      dmem[wr_ptr] <= i_imem_rdata;
      pmem[wr_ptr] <= tmem[tg_rd];
    end
  end

endmodule

// File: tb/tb_bure_if_prefetch.sv
// Directed bench for bure_if_prefetch with an in-order memory responder.
module tb_bure_if_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redir_pc;
  logic        ivalid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;
  int gcnt;
  bit hold;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  bure_if_prefetch dut (
    .i_clk        (clk),
    .i_rstn       (rst_n),
    .o_imem_req   (req),
    .o_imem_addr  (addr),
    .i_imem_gnt   (gnt),
    .i_imem_rvalid(rvalid),
    .i_imem_rdata (rdata),
    .i_redirect   (redirect),
    .i_redirect_pc(redir_pc),
    .o_instr_valid(ivalid),
    .o_instr      (instr),
    .o_instr_pc   (ipc),
    .i_instr_ready(ready)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      gcnt <= 0;
    end else if (req && gnt) begin
      q.push_back(addr);
      gcnt <= gcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && !hold && q.size() > 0) begin
      rvalid <= 1'b1;
      rdata  <= q.pop_front() ^ 32'hA5A5_0000;
    end else begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; gnt = 1'b1; ready = 1'b1; redirect = 1'b0;
    redir_pc = '0; hold = 1'b0; rvalid = 1'b0; rdata = '0;
    #2;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", 32'(ivalid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", ipc, 32'h0);

    // streaming: one word per cycle
    do_reset();
    chk("t1_req_norun", 32'(req), 32'd0);
    step();
    chk("t1_req_e1", 32'(req), 32'd1);
    chk("t1_addr_e1", addr, 32'h0);
    chk("t1_valid_e1", 32'(ivalid), 32'd0);
    step();
    chk("t1_addr_e2", addr, 32'h4);
    chk("t1_valid_e2", 32'(ivalid), 32'd0);
    step();
    chk("t1_valid_e3", 32'(ivalid), 32'd1);
    chk("t1_pc_e3", ipc, 32'h0);
    chk("t1_instr_e3", instr, 32'hA5A5_0000);
    step();
    chk("t1_pc_e4", ipc, 32'h4);
    chk("t1_instr_e4", instr, 32'hA5A5_0004);
    step();
    chk("t1_pc_e5", ipc, 32'h8);

    // back-pressure: credit limit of four
    ready = 1'b0;
    do_reset();
    repeat (6) step();
    chk("t2_req_full", 32'(req), 32'd0);
    chk("t2_valid", 32'(ivalid), 32'd1);
    chk("t2_pc_hold", ipc, 32'h0);
    chk("t2_gcnt", 32'(gcnt), 32'd4);
    step();
    chk("t2_req_full2", 32'(req), 32'd0);
    chk("t2_pc_hold2", ipc, 32'h0);
    chk("t2_gcnt2", 32'(gcnt), 32'd4);
    ready = 1'b1;
    #1;
    chk("t2_req_pre", 32'(req), 32'd0);
    step();
    chk("t2_pc_d1", ipc, 32'h4);
    chk("t2_req_res", 32'(req), 32'd1);
    chk("t2_addr_res", addr, 32'h10);
    step();
    chk("t2_pc_d2", ipc, 32'h8);
    step();
    chk("t2_pc_d3", ipc, 32'hC);
    step();
    chk("t2_pc_d4", ipc, 32'h10);

    // grant withheld at 0x8
    ready = 1'b1;
    do_reset();
    step();
    chk("t3_addr0", addr, 32'h0);
    step();
    chk("t3_addr4", addr, 32'h4);
    step();
    chk("t3_addr8", addr, 32'h8);
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_req", 32'(req), 32'd1);
      chk("t3_hold_addr", addr, 32'h8);
    end
    gnt = 1'b1;
    step();
    chk("t3_addrC", addr, 32'hC);

    // redirect with two in flight and one buffered
    do_reset();
    repeat (6) step();
    chk("t4_addr14", addr, 32'h14);
    chk("t4_headC", ipc, 32'hC);
    hold = 1'b1;
    ready = 1'b0;
    step();
    chk("t4_addr18", addr, 32'h18);
    chk("t4_headC2", ipc, 32'hC);
    redirect = 1'b1;
    redir_pc = 32'h1003;
    #1;
    chk("t4_req_redir", 32'(req), 32'd0);
    step();
    redirect = 1'b0;
    hold = 1'b0;
    #1;
    chk("t4_flushed", 32'(ivalid), 32'd0);
    chk("t4_addr1000", addr, 32'h1000);
    chk("t4_req_after", 32'(req), 32'd1);
    step();
    chk("t4_drop1", 32'(ivalid), 32'd0);
    chk("t4_addr1004", addr, 32'h1004);
    step();
    chk("t4_drop2", 32'(ivalid), 32'd0);
    step();
    chk("t4_valid", 32'(ivalid), 32'd1);
    chk("t4_pc1000", ipc, 32'h1000);
    chk("t4_instr", instr, 32'hA5A5_1000);

    // redirect coincident with rvalid and ready
    ready = 1'b1;
    do_reset();
    repeat (6) step();
    redirect = 1'b1;
    redir_pc = 32'h2000;
    #1;
    chk("t5_req_redir", 32'(req), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("t5_flushed", 32'(ivalid), 32'd0);
    chk("t5_addr2000", addr, 32'h2000);
    chk("t5_req_after", 32'(req), 32'd1);
    step();
    chk("t5_empty", 32'(ivalid), 32'd0);
    step();
    chk("t5_valid", 32'(ivalid), 32'd1);
    chk("t5_pc2000", ipc, 32'h2000);
    chk("t5_instr", instr, 32'hA5A5_2000);

    // asynchronous reset mid-stream
    ready = 1'b0;
    do_reset();
    repeat (4) step();
    chk("t6_valid_pre", 32'(ivalid), 32'd1);
    chk("t6_pc_pre", ipc, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(ivalid), 32'd0);
    chk("t6_req_rst", 32'(req), 32'd0);
    chk("t6_addr_rst", addr, 32'h0);
    chk("t6_instr_rst", instr, 32'h0);
    chk("t6_pc_rst", ipc, 32'h0);
    do_reset();
    step();
    chk("t6_req_restart", 32'(req), 32'd1);
    chk("t6_addr_restart", addr, 32'h0);
    repeat (2) step();
    chk("t6_valid_restart", 32'(ivalid), 32'd1);
    chk("t6_pc_restart", ipc, 32'h0);

    // PC wrap after redirect near the top of memory
    do_reset();
    step();
    redirect = 1'b1;
    redir_pc = 32'hFFFF_FFFF;
    #1;
    chk("t7_req_redir", 32'(req), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("t7_addr_top", addr, 32'hFFFF_FFFC);
    chk("t7_req", 32'(req), 32'd1);
    step();
    chk("t7_addr_wrap", addr, 32'h0);
    step();
    chk("t7_valid", 32'(ivalid), 32'd1);
    chk("t7_pc_top", ipc, 32'hFFFF_FFFC);
    chk("t7_instr", instr, 32'h5A5A_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bure_if_prefetch.md
Name: bure_if_prefetch

Overview:
Instruction prefetch unit feeding the instruction decode stage. Generates sequential fetch addresses and issues requests to instruction memory with a req/gnt/rvalid handshake. Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake. Handles control-flow redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
ADDR_WIDTH, 32, fetch address / PC width
INSTR_WIDTH, 32, instruction word width
DEPTH, 4, FIFO entries; also the maximum in-flight plus buffered words (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rstn  in  1  asynchronous active-low reset
o_imem_req  out  1  fetch request
o_imem_addr  out  ADDR_WIDTH  fetch address, low 2 bits always 0
i_imem_gnt  in  1  request accepted this cycle when o_imem_req=1
i_imem_rvalid  in  1  response data valid; responses are in order
i_imem_rdata  in  INSTR_WIDTH  response instruction word
i_redirect  in  1  flush and restart fetch
i_redirect_pc  in  ADDR_WIDTH  new fetch PC; low 2 bits ignored
o_instr_valid  out  1  FIFO head valid toward decode
o_instr  out  INSTR_WIDTH  head instruction
o_instr_pc  out  ADDR_WIDTH  head instruction PC
i_instr_ready  in  1  decode accepts head

Behaviour:
- Reset, asynchronous: fetch PC=RESET_PC, inflight=0, discard=0, FIFO count=0, run=0. Outputs: o_imem_req=0, o_imem_addr=RESET_PC, o_instr_valid=0, o_instr=0, o_instr_pc=0. Reset mid-operation drops all state immediately.
- run flag sets on the first clock edge after reset release. First request is asserted in the cycle after that.
- o_imem_req = run & !i_redirect & (inflight + count < DEPTH). o_imem_addr = fetch PC.
- Request handshake: req&gnt accepts one request. The PC advances by 4 and inflight increments. PC wraps modulo 2^ADDR_WIDTH. Without gnt, req and addr hold stable unless a redirect occurs.
- Response: rvalid decrements inflight.
  - If discard>0, the word is dropped and discard decrements.
  - Otherwise {rdata, PC} is written to the FIFO tail. The PC of each in-flight request is held in a parallel DEPTH-entry tag queue.
- rvalid with inflight=0 is a protocol error: ignored, no state change.
- Latency: gnt in cycle t, rvalid in cycle t+1 or later; o_instr_valid high one cycle after rvalid. There is no bypass.
- Credit rule guarantees no FIFO overflow; rvalid is never back-pressured.
- Output: o_instr_valid = count>0. Head fields stay stable while valid & !ready. Pop on valid & ready.
- A push and pop in the same cycle leaves count unchanged. Push into an empty FIFO with ready=1 is not visible until the next cycle.
- Redirect (highest priority), on the clock edge:
  - FIFO flushed (count=0) and tag queue cleared.
  - fetch PC = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - discard = inflight - (i_imem_rvalid ? 1 : 0). Any response arriving in the redirect cycle is dropped.
  - o_imem_req is forced 0 during the redirect cycle, so no grant is ambiguous.
  - A pop in the same cycle is a don't-care, since the entry is flushed anyway.
  - Stale in-flight requests keep consuming credit until returned.
- Back-to-back redirects: each one re-applies the same rules; discard is recomputed from the current inflight.
- Internal counters are clog2(DEPTH)+1 bits; inflight+count never exceeds DEPTH.

Test Plan:
- Reset release with gnt tied 1 and rvalid one cycle after gnt, rdata=addr^32'hA5A5_0000, ready=1 -> addresses 0,4,8,... Decode sees instr_pc 0,4,8 one per cycle, first o_instr_valid 3 cycles after reset release.
- ready=0, gnt=1, single-cycle response -> exactly DEPTH=4 requests (0x0-0xC) issued, then req=0. o_instr_pc=0x0 stays stable. Raising ready drains 4 entries in order and req resumes at 0x10.
- gnt withheld 3 cycles at addr 0x8 -> req and addr stay 0x8 each cycle. Advances to 0xC only after gnt.
- Redirect to 0x1003 with 2 requests in flight (0x10, 0x14) and 1 buffered -> FIFO empty next cycle. Two responses dropped. Next request addr 0x1000, first delivered instr_pc 0x1000.
- Redirect in the same cycle as rvalid and ready -> that word dropped, o_imem_req=0 that cycle, discard = inflight-1.
- Assert i_rstn=0 mid-stream with FIFO half full -> o_instr_valid and o_imem_req fall immediately. After release, fetch restarts at RESET_PC.
